// File: rtl/syscall_pkg.sv
// ---------------------------------------------------------------------------
// syscall_pkg
// Shared constants and types for the syscall service unit:
//   - MIPS service codes held in $v0 when `syscall` executes
//   - register-file indices of $v0 / $a0
//   - ASCII characters used by the integer print/read services
//   - FSM state encodings for the top-level unit and the itoa converter
//   - powers-of-ten table that drives the digit-by-digit conversion
// ---------------------------------------------------------------------------
package syscall_pkg;

   // Service codes (compared against the full 32-bit $v0 value).
   localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
   localparam logic [31:0] SYS_READ_INT   = 32'd5;
   localparam logic [31:0] SYS_EXIT       = 32'd10;
   localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;
   localparam logic [31:0] SYS_READ_CHAR  = 32'd12;

   // Register-file indices.
   localparam logic [4:0] REG_V0 = 5'd2;
   localparam logic [4:0] REG_A0 = 5'd4;

   // Characters.
   localparam logic [7:0] ASCII_MINUS = 8'h2D;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_NINE  = 8'h39;
   localparam logic [7:0] ASCII_NL    = 8'h0A;

   // Top-level service FSM.
   typedef enum logic [3:0] {
      ST_IDLE,
      ST_DECODE,
      ST_ITOA,
      ST_SEND,
      ST_RD_WAIT,
      ST_ECHO,
      ST_WB,
      ST_ERR,
      ST_HALT
   } state_t;

   // Integer-to-ASCII converter FSM.
   typedef enum logic [1:0] {
      IT_IDLE,
      IT_DIV,
      IT_EMIT
   } itoa_state_t;

   // 10^0 .. 10^9, indexed by decimal digit position.
   localparam int NUM_POW10 = 10;
   localparam logic [31:0] POW10 [NUM_POW10] = '{
      32'd1,        32'd10,        32'd100,        32'd1000,
      32'd10000,    32'd100000,    32'd1000000,    32'd10000000,
      32'd100000000, 32'd1000000000
   };

   // Table lookup with a safe value for unused index codes.
   function automatic logic [31:0] pow10(input logic [3:0] idx);
      logic [31:0] val;
      val = 32'd1;
      if (idx < 4'(NUM_POW10)) val = POW10[idx];
      return val;
   endfunction

endpackage : syscall_pkg

// File: rtl/syscall_itoa.sv
// ---------------------------------------------------------------------------
// syscall_itoa
// Converts a signed 32-bit value into its decimal ASCII representation and
// streams the characters out over a valid/ready interface, most significant
// digit first. A leading '-' is emitted for negative values; the magnitude
// is the two's-complement negation taken as unsigned, so 0x80000000 prints
// as -2147483648. Leading zeros are suppressed; zero prints as "0".
// Each digit is found by repeated subtraction of 10^idx, one subtraction per
// cycle (at most 9 cycles per digit).
//
// Parameters:
//   MAX_DIGITS  - decimal digit positions scanned (10 for 32 bits)
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   start_i       - begin converting value_i (accepted only when idle)
//   value_i       - signed value to convert
//   out_data_o    - character to send
//   out_valid_o   - out_data_o valid
//   out_ready_i   - sink accepts out_data_o
//   done_o        - one-cycle pulse after the last character is accepted
// ---------------------------------------------------------------------------
module syscall_itoa
   import syscall_pkg::*;
#(
   parameter int MAX_DIGITS = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic [31:0] value_i,
   output logic [7:0]  out_data_o,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic        done_o
);

   itoa_state_t state_q;
   logic [31:0] mag_q;        // remaining magnitude
   logic [3:0]  idx_q;        // current digit position (power of ten)
   logic [3:0]  dig_q;        // subtractions done for current digit
   logic        started_q;    // a non-zero digit has been emitted
   logic        sign_q;       // character in flight is the '-' sign
   logic [7:0]  out_data_q;
   logic        out_valid_q;
   logic        done_q;

   logic [31:0] pw;
   logic [31:0] rem_d;
   logic [3:0]  cnt_d;
   logic        digit_done;

   // One subtraction step; the digit is complete once the remainder drops
   // below the current power, so no cycle is spent on a failing compare.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path
      // leaves it unassigned, which would infer a latch.
      pw    = pow10(idx_q);
      rem_d = mag_q;
      cnt_d = dig_q;
      if (mag_q >= pw) begin
         rem_d = mag_q - pw;
         cnt_d = dig_q + 4'd1;
      end
   end

   assign digit_done = (rem_d < pw);

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      if (!rst_n) begin
         state_q     <= IT_IDLE;
         mag_q       <= '0;
         idx_q       <= '0;
         dig_q       <= '0;
         started_q   <= 1'b0;
         sign_q      <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            IT_IDLE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  mag_q     <= value_i[31] ? (~value_i + 32'd1) : value_i;
                  idx_q     <= 4'(MAX_DIGITS - 1);
                  dig_q     <= '0;
                  started_q <= 1'b0;
                  sign_q    <= value_i[31];
                  if (value_i[31]) begin
                     out_data_q  <= ASCII_MINUS;
                     out_valid_q <= 1'b1;
                     state_q     <= IT_EMIT;
                  end else begin
                     state_q <= IT_DIV;
                  end
               end
            end

            IT_DIV: begin
               mag_q <= rem_d;
               if (!digit_done) begin
                  dig_q <= cnt_d;
               end else begin
                  dig_q <= '0;
                  // Units digit is always printed so that zero yields "0".
                  if (cnt_d != 4'd0 || started_q || idx_q == 4'd0) begin
                     out_data_q  <= ASCII_ZERO + {4'd0, cnt_d};
                     out_valid_q <= 1'b1;
                     started_q   <= 1'b1;
                     state_q     <= IT_EMIT;
                  end else begin
                     idx_q <= idx_q - 4'd1;
                  end
               end
            end

            IT_EMIT: begin
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  if (sign_q) begin
                     sign_q  <= 1'b0;
                     state_q <= IT_DIV;
                  end else if (idx_q == 4'd0) begin
                     done_q  <= 1'b1;
                     state_q <= IT_IDLE;
                  end else begin
                     idx_q   <= idx_q - 4'd1;
                     state_q <= IT_DIV;
                  end
               end
            end

            default: state_q <= IT_IDLE;
         endcase
      end
   end

   assign out_data_o  = out_data_q;
   assign out_valid_o = out_valid_q;
   assign done_o      = done_q;

endmodule : syscall_itoa

// File: rtl/syscall_unit.sv
// ---------------------------------------------------------------------------
// syscall_unit
// Services the MIPS `syscall` instruction. On a syscall pulse the $v0
// service code and $a0 argument are captured; the unit then prints an
// integer or character over the tx channel, reads an integer or character
// from the rx channel and writes it back to $v0, halts on exit, or flags an
// unknown code. The pipeline is stalled for the whole service.
//
// Build option:
//   SYSCALL_ECHO_EN - when defined, every character accepted by a read is
//                     echoed on tx before the next one is accepted.
//
// Parameters:
//   V0_IDX      - register index written with read results
//   MAX_DIGITS  - decimal digits for a 32-bit magnitude
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   syscall               - one-cycle pulse: syscall decoded
//   v0, a0                - register-file $v0 / $a0 values
//   stall                 - hold PC/pipeline
//   halted                - exit taken (sticky until reset)
//   err                   - one-cycle pulse: unknown service code
//   tx_data/valid/ready   - output character channel
//   rx_data/valid/ready   - input character channel
//   rf_write/_reg/wdata   - register-file write port
// ---------------------------------------------------------------------------
module syscall_unit
   import syscall_pkg::*;
#(
   parameter int V0_IDX     = 2,
   parameter int MAX_DIGITS = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        syscall,
   input  logic [31:0] v0,
   input  logic [31:0] a0,
   output logic        stall,
   output logic        halted,
   output logic        err,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic        rf_write,
   output logic [4:0]  rf_write_reg,
   output logic [31:0] rf_wdata
);

   state_t      state_q;
   logic [31:0] code_q;
   logic [31:0] arg_q;
   logic [31:0] acc_q;         // read_int accumulator (wraps mod 2^32)
   logic        neg_q;         // read_int saw a leading '-'
   logic        first_q;       // next rx character is the first of the read
   logic [7:0]  tx_data_q;
   logic        tx_valid_q;
   logic        halted_q;
   logic        err_q;
   logic        rf_write_q;
   logic [4:0]  rf_write_reg_q;
   logic [31:0] rf_wdata_q;
`ifdef SYSCALL_ECHO_EN
   logic        fin_q;         // echo in flight ends the read
`endif

   logic        itoa_start;
   logic        itoa_ready;
   logic [7:0]  itoa_data;
   logic        itoa_valid;
   logic        itoa_done;

   logic        rx_fire;
   logic        rx_is_digit;
   logic        rx_is_lead_minus;
   logic        rx_last;
   logic [31:0] acc_x10;
   logic [31:0] rx_result;

   // ---------------------------------------------------------------------
   // Integer-to-ASCII converter; its stream is muxed onto tx while printing.
   // ---------------------------------------------------------------------
   assign itoa_start = (state_q == ST_DECODE) && (code_q == SYS_PRINT_INT);
   assign itoa_ready = tx_ready && (state_q == ST_ITOA);

   syscall_itoa #(
      .MAX_DIGITS (MAX_DIGITS)
   ) u_itoa (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (itoa_start),
      .value_i     (arg_q),
      .out_data_o  (itoa_data),
      .out_valid_o (itoa_valid),
      .out_ready_i (itoa_ready),
      .done_o      (itoa_done)
   );

   // ---------------------------------------------------------------------
   // Read-path decode of the incoming character.
   // ---------------------------------------------------------------------
   assign rx_ready         = (state_q == ST_RD_WAIT);
   assign rx_fire          = rx_valid && rx_ready;
   assign rx_is_digit      = (rx_data >= ASCII_ZERO) && (rx_data <= ASCII_NINE);
   assign rx_is_lead_minus = first_q && (rx_data == ASCII_MINUS);
   assign acc_x10          = (acc_q << 3) + (acc_q << 1);

   always_comb begin
      rx_last   = 1'b0;
      rx_result = neg_q ? (~acc_q + 32'd1) : acc_q;
      if (code_q == SYS_READ_CHAR) begin
         rx_last   = 1'b1;
         rx_result = {24'd0, rx_data};
      end else if (!rx_is_lead_minus && !rx_is_digit) begin
         rx_last = 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Service FSM.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         code_q         <= '0;
         arg_q          <= '0;
         acc_q          <= '0;
         neg_q          <= 1'b0;
         first_q        <= 1'b0;
         tx_data_q      <= '0;
         tx_valid_q     <= 1'b0;
         halted_q       <= 1'b0;
         err_q          <= 1'b0;
         rf_write_q     <= 1'b0;
         rf_write_reg_q <= '0;
         rf_wdata_q     <= '0;
`ifdef SYSCALL_ECHO_EN
         fin_q          <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (syscall && !halted_q) begin
                  code_q  <= v0;
                  arg_q   <= a0;
                  state_q <= ST_DECODE;
               end
            end

            ST_DECODE: begin
               case (code_q)
                  SYS_PRINT_INT:  state_q <= ST_ITOA;
                  SYS_PRINT_CHAR: begin
                     tx_data_q  <= arg_q[7:0];
                     tx_valid_q <= 1'b1;
                     state_q    <= ST_SEND;
                  end
                  SYS_READ_INT, SYS_READ_CHAR: begin
                     acc_q   <= '0;
                     neg_q   <= 1'b0;
                     first_q <= 1'b1;
                     state_q <= ST_RD_WAIT;
                  end
                  SYS_EXIT: begin
                     halted_q <= 1'b1;
                     state_q  <= ST_HALT;
                  end
                  default: begin
                     err_q   <= 1'b1;
                     state_q <= ST_ERR;
                  end
               endcase
            end

            ST_ITOA: begin
               if (itoa_done) state_q <= ST_IDLE;
            end

            ST_SEND: begin
               if (tx_ready) begin
                  tx_valid_q <= 1'b0;
                  state_q    <= ST_IDLE;
               end
            end

            ST_RD_WAIT: begin
               if (rx_fire) begin
                  first_q <= 1'b0;
                  if (rx_is_lead_minus) neg_q <= 1'b1;
                  if (rx_is_digit) acc_q <= acc_x10 + {28'd0, rx_data[3:0]};
                  if (rx_last) rf_wdata_q <= rx_result;
`ifdef SYSCALL_ECHO_EN
                  tx_data_q  <= rx_data;
                  tx_valid_q <= 1'b1;
                  fin_q      <= rx_last;
                  state_q    <= ST_ECHO;
`else
                  if (rx_last) begin
                     rf_write_q     <= 1'b1;
                     rf_write_reg_q <= 5'(V0_IDX);
                     state_q        <= ST_WB;
                  end
`endif
               end
            end

`ifdef SYSCALL_ECHO_EN
            ST_ECHO: begin
               if (tx_ready) begin
                  tx_valid_q <= 1'b0;
                  if (fin_q) begin
                     rf_write_q     <= 1'b1;
                     rf_write_reg_q <= 5'(V0_IDX);
                     state_q        <= ST_WB;
                  end else begin
                     state_q <= ST_RD_WAIT;
                  end
               end
            end
`endif

            ST_WB: begin
               rf_write_q     <= 1'b0;
               rf_write_reg_q <= '0;
               rf_wdata_q     <= '0;
               state_q        <= ST_IDLE;
            end

            ST_ERR: begin
               err_q   <= 1'b0;
               state_q <= ST_IDLE;
            end

            ST_HALT: state_q <= ST_HALT;

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Outputs. Stall is raised combinationally in the capture cycle so the
   // instruction after the syscall never advances; gating with rst_n keeps
   // every output low while reset is asserted.
   // ---------------------------------------------------------------------
   assign stall        = rst_n && ((state_q != ST_IDLE) || (syscall && !halted_q));
   assign halted       = halted_q;
   assign err          = err_q;
   assign tx_valid     = (state_q == ST_ITOA) ? itoa_valid : tx_valid_q;
   assign tx_data      = (state_q == ST_ITOA) ? itoa_data  : tx_data_q;
   assign rf_write     = rf_write_q;
   assign rf_write_reg = rf_write_reg_q;
   assign rf_wdata     = rf_wdata_q;

endmodule : syscall_unit

// File: tb/tb_syscall_unit.sv
// ---------------------------------------------------------------------------
// tb_syscall_unit
// Self-checking bench for syscall_unit. Expected tx characters and register
// writes are produced by a behavioural model ($sformatf decimal formatting
// for prints, a character-by-character parser for reads) and queued; one
// monitor process compares every tx transfer and register write against the
// queues each cycle. Literal strings/values pin the model itself.
// ---------------------------------------------------------------------------
module tb_syscall_unit;

   logic        clk;
   logic        rst_n;
   logic        syscall;
   logic [31:0] v0;
   logic [31:0] a0;
   logic        stall;
   logic        halted;
   logic        err;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        rf_write;
   logic [4:0]  rf_write_reg;
   logic [31:0] rf_wdata;

   int checks   = 0;
   int failures = 0;

   logic [7:0]  exp_tx[$];
   logic [31:0] exp_wr[$];
   string       got_tx;
   int          rf_cnt  = 0;
   int          err_cnt = 0;

   bit          rdy_mode = 1'b0;   // 0: always ready, 1: pattern 1,0,0,1
   logic [3:0]  rdy_pat  = 4'b1001;

   bit          hold_pend = 1'b0;
   logic [7:0]  hold_data = '0;

   syscall_unit #(
      .V0_IDX     (2),
      .MAX_DIGITS (10)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .syscall      (syscall),
      .v0           (v0),
      .a0           (a0),
      .stall        (stall),
      .halted       (halted),
      .err          (err),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .rf_write     (rf_write),
      .rf_write_reg (rf_write_reg),
      .rf_wdata     (rf_wdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached, required finish before limit");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_str(input string name, input string act, input string exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got \"%s\" required \"%s\"", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   task automatic model_print_int(input logic [31:0] val);
      string s;
      s = $sformatf("%0d", $signed(val));
      for (int i = 0; i < s.len(); i++) exp_tx.push_back(s[i]);
   endtask

   function automatic logic [31:0] model_read_int(input string s);
      logic [31:0] acc;
      bit          neg;
      bit          stop;
      byte         c;
      acc  = 32'd0;
      neg  = 1'b0;
      stop = 1'b0;
      for (int i = 0; i < s.len(); i++) begin
         c = s[i];
         if (!stop) begin
            if (i == 0 && c == "-") neg = 1'b1;
            else if (c >= "0" && c <= "9") acc = acc * 32'd10 + 32'(c - 8'h30);
            else stop = 1'b1;
         end
      end
      return neg ? (32'd0 - acc) : acc;
   endfunction

   task automatic model_echo(input string s);
`ifdef SYSCALL_ECHO_EN
      for (int i = 0; i < s.len(); i++) exp_tx.push_back(s[i]);
`else
      if (s.len() < 0) exp_tx.push_back(8'h00);
`endif
   endtask

   // ---------------- tx_ready driver ----------------
   initial begin
      int cyc;
      cyc = 0;
      tx_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode) begin
            tx_ready = rdy_pat[3 - (cyc % 4)];
            cyc++;
         end else begin
            tx_ready = 1'b1;
            cyc = 0;
         end
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            check("tx_hold_valid", {31'd0, tx_valid}, 32'd1);
            check("tx_hold_data", {24'd0, tx_data}, {24'd0, hold_data});
         end
         hold_pend = tx_valid && !tx_ready;
         hold_data = tx_data;

         if (tx_valid && tx_ready) begin
            check("tx_expected", 32'(exp_tx.size() != 0), 32'd1);
            if (exp_tx.size() != 0) check("tx_char", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
            got_tx = {got_tx, $sformatf("%c", tx_data)};
         end

         if (rf_write) begin
            rf_cnt++;
            check("rf_write_expected", 32'(exp_wr.size() != 0), 32'd1);
            check("rf_write_reg", {27'd0, rf_write_reg}, 32'd2);
            if (exp_wr.size() != 0) check("rf_wdata", rf_wdata, exp_wr.pop_front());
         end

         if (err) err_cnt++;
         if (tx_valid || rx_ready || rf_write || err)
            check("stall_while_busy", {31'd0, stall}, 32'd1);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_syscall(input logic [31:0] code, input logic [31:0] arg);
      @(posedge clk);
      #1;
      v0      = code;
      a0      = arg;
      syscall = 1'b1;
      @(negedge clk);
      check("stall_on_pulse", {31'd0, stall}, 32'd1);
      @(posedge clk);
      #1;
      syscall = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output int cyc);
      cyc = 0;
      @(negedge clk);
      while (stall && cyc < budget) begin
         cyc++;
         @(negedge clk);
      end
      check("stall_drops", {31'd0, stall}, 32'd0);
   endtask

   task automatic feed_rx(input string s);
      int t;
      bit done;
      for (int i = 0; i < s.len(); i++) begin
         rx_data  = s[i];
         rx_valid = 1'b1;
         t    = 0;
         done = 1'b0;
         while (!done && t < 200) begin
            @(negedge clk);
            if (rx_ready) done = 1'b1;
            t++;
         end
         check("rx_accepted", {31'd0, done}, 32'd1);
         @(posedge clk);
         #1;
         rx_valid = 1'b0;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_stall"}, {31'd0, stall}, 32'd0);
      check({tag, "_halted"}, {31'd0, halted}, 32'd0);
      check({tag, "_err"}, {31'd0, err}, 32'd0);
      check({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
      check({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
      check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
      check({tag, "_rf_write"}, {31'd0, rf_write}, 32'd0);
      check({tag, "_rf_write_reg"}, {27'd0, rf_write_reg}, 32'd0);
      check({tag, "_rf_wdata"}, rf_wdata, 32'd0);
   endtask

   // ---------------- directed tests ----------------
   logic [31:0] pi_vals [3] = '{32'hFFFF_FECF, 32'h0000_0000, 32'h8000_0000};
   string       pi_strs [3] = '{"-305", "0", "-2147483648"};

   initial begin
      int cyc;
      int rf0;
      int err0;
      rst_n    = 1'b0;
      syscall  = 1'b0;
      v0       = '0;
      a0       = '0;
      rx_data  = '0;
      rx_valid = 1'b0;
      got_tx   = "";

      // Model pins.
      check("model_read_neg42", model_read_int("-42\n"), 32'hFFFF_FFD6);
      check("model_read_wrap", model_read_int("4294967297\n"), 32'd1);
      check("model_read_lone_minus", model_read_int("-\n"), 32'd0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // print_char 'A'
      got_tx = "";
      rf0    = rf_cnt;
      exp_tx.push_back(8'h41);
      do_syscall(32'd11, 32'h41);
      wait_idle(100, cyc);
      check("print_char_stall_cycles", cyc, 32'd2);
      check_str("print_char_text", got_tx, "A");
      check("print_char_no_write", rf_cnt, rf0);

      // print_int with full-rate sink
      for (int k = 0; k < 3; k++) begin
         got_tx = "";
         model_print_int(pi_vals[k]);
         do_syscall(32'd1, pi_vals[k]);
         wait_idle(500, cyc);
         check_str("print_int_text", got_tx, pi_strs[k]);
         check("print_int_all_sent", exp_tx.size(), 32'd0);
      end

      // print_int with back-pressure
      got_tx   = "";
      rdy_mode = 1'b1;
      model_print_int(32'd12345);
      do_syscall(32'd1, 32'd12345);
      wait_idle(2000, cyc);
      rdy_mode = 1'b0;
      check_str("print_int_bp_text", got_tx, "12345");
      check("print_int_bp_all_sent", exp_tx.size(), 32'd0);

      // read_int "-42\n"
      rf0 = rf_cnt;
      exp_wr.push_back(model_read_int("-42\n"));
      model_echo("-42\n");
      do_syscall(32'd5, 32'd0);
      feed_rx("-42\n");
      wait_idle(200, cyc);
      check("read_int_one_write", rf_cnt - rf0, 32'd1);
      check("read_int_wr_drained", exp_wr.size(), 32'd0);

      // read_int wraps modulo 2^32
      rf0 = rf_cnt;
      exp_wr.push_back(model_read_int("4294967297\n"));
      model_echo("4294967297\n");
      do_syscall(32'd5, 32'd0);
      feed_rx("4294967297\n");
      wait_idle(200, cyc);
      check("read_wrap_one_write", rf_cnt - rf0, 32'd1);

      // read_char 'z'
      rf0 = rf_cnt;
      exp_wr.push_back(32'h7A);
      model_echo("z");
      do_syscall(32'd12, 32'd0);
      feed_rx("z");
      wait_idle(200, cyc);
      check("read_char_one_write", rf_cnt - rf0, 32'd1);
      check("reads_tx_drained", exp_tx.size(), 32'd0);

      // unknown code 7
      rf0  = rf_cnt;
      err0 = err_cnt;
      do_syscall(32'd7, 32'd0);
      wait_idle(50, cyc);
      check("err_one_pulse", err_cnt - err0, 32'd1);
      check("err_no_write", rf_cnt, rf0);

      // exit, then ignored syscall
      got_tx = "";
      do_syscall(32'd10, 32'd0);
      repeat (5) @(negedge clk);
      check("halt_halted", {31'd0, halted}, 32'd1);
      check("halt_stall", {31'd0, stall}, 32'd1);
      do_syscall(32'd11, 32'h51);
      repeat (20) @(negedge clk);
      check("halt_still_halted", {31'd0, halted}, 32'd1);
      check("halt_still_stall", {31'd0, stall}, 32'd1);
      check_str("halt_no_tx", got_tx, "");

      // reset clears halt
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_all_zero("halt_reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // reset mid-digit during print_int aborts the service
      got_tx = "";
      model_print_int(32'h8000_0000);
      do_syscall(32'd1, 32'h8000_0000);
      repeat (6) @(posedge clk);
      #1;
      rst_n = 1'b0;
      exp_tx.delete();
      #1;
      check_all_zero("abort_reset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check("abort_stall_low", {31'd0, stall}, 32'd0);
      check("abort_partial_tx", 32'(got_tx.len() < 11), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_syscall_unit
